bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master to one-peripheral-bridge arbiter.
//
// A request seen in IDLE is latched into holding registers and given one
// ACCESS cycle on the bridge, where the bridge read data is captured. In the
// following RESP cycle the granted master gets a one-cycle ack together with
// the captured read data. Ties go round-robin by default.
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, ties always go to master 0 and the
//                      last-grant pointer is not built.
//
// Ports:
//   CLK                 clock, rising edge
//   RST                 asynchronous active-low reset
//   m0_req/m1_req       level requests, held until the matching ack
//   m*_addr/m*_wd/m*_we master address, write data, write enable
//   m*_ack              one-cycle completion pulse
//   m*_rd               read data, valid with ack, 0 otherwise
//   bus_addr/bus_wd     bridge address / write data (hold last latched value)
//   bus_we              bridge write enable, only ever high in ACCESS
//   bus_rd              combinational read data from the bridge
//   gnt_id              master owning the bus (meaningful while busy)
//   busy                high in ACCESS and RESP
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; winner is latched on leaving
// ACCESS | one bridge cycle with the latched request; bus_rd captured
// RESP   | ack pulse and read data to the granted master
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  input  logic              m0_we,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  input  logic              m1_we,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wd,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rd,
  output logic              gnt_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              pick;

`ifdef ARB_FIXED_PRIO_EN
  // Master 0 wins whenever it asks.
  always_comb begin
    pick = ~m0_req;
  end
`else
  logic last_q, last_d;

  // On a tie the master that was not granted last wins.
  always_comb begin
    pick = (m0_req && m1_req) ? ~last_q : m1_req;
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    rd_d    = rd_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = pick;
          addr_d  = pick ? m1_addr : m0_addr;
          wd_d    = pick ? m1_wd   : m0_wd;
          we_d    = pick ? m1_we   : m0_we;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = pick;
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rd_d    = bus_rd;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;  // master 0 wins the first tie
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs decode straight from registered state, so an async reset
  // removes bus_we and acks immediately.
  always_comb begin
    bus_addr = addr_q;
    bus_wd   = wd_q;
    bus_we   = (state_q == S_ACCESS) && we_q;
    gnt_id   = gnt_q;
    busy     = (state_q != S_IDLE);
    m0_ack   = (state_q == S_RESP) && !gnt_q;
    m1_ack   = (state_q == S_RESP) && gnt_q;
    m0_rd    = m0_ack ? rd_q : '0;
    m1_rd    = m1_ack ? rd_q : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wd = '0, m1_addr = '0, m1_wd = '0;
  logic [31:0] bus_rd = '0;
  logic        m0_ack, m1_ack, bus_we, gnt_id, busy;
  logic [31:0] m0_rd, m1_rd, bus_addr, bus_wd;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef ARB_FIXED_PRIO_EN
  localparam logic TIE2 = 1'b0;  // winner of a tie after a master-0 grant
`else
  localparam logic TIE2 = 1'b1;
`endif

  always #5 CLK = ~CLK;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_rd(m1_rd),
    .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_we(bus_we), .bus_rd(bus_rd),
    .gnt_id(gnt_id), .busy(busy)
  );

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wd;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wd;
    logic [31:0] rd_in;
    logic        exp_gnt, exp_we;
    logic [31:0] exp_addr, exp_wd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drop_reqs();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    // inputs: m0 {req,we,addr,wd}, m1 {req,we,addr,wd}, bus_rd
    // expected: gnt, bus_we, bus_addr, bus_wd
    vecs[0] = '{1, 1, 32'h7F34, 32'h0000_00FF, 0, 0, 32'h0, 32'h0, 32'hAAAA_5555,
                0, 1, 32'h7F34, 32'h0000_00FF};
    vecs[1] = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h7F00, 32'hDEAD_0001, 32'h1234_5678,
                1, 0, 32'h7F00, 32'hDEAD_0001};
    vecs[2] = '{1, 0, 32'h100, 32'h11, 1, 1, 32'h200, 32'h22, 32'hCAFE_0000,
                0, 0, 32'h100, 32'h11};
    vecs[3] = '{1, 0, 32'h100, 32'h11, 1, 1, 32'h200, 32'h22, 32'hCAFE_0001,
                TIE2, TIE2, TIE2 ? 32'h200 : 32'h100, TIE2 ? 32'h22 : 32'h11};
    vecs[4] = '{0, 1, 32'h5, 32'h5, 1, 1, 32'h444, 32'h4444, 32'h0BAD_F00D,
                1, 1, 32'h444, 32'h4444};
    vecs[5] = '{1, 0, 32'h555, 32'h55, 0, 1, 32'h6, 32'h6, 32'h5555_0000,
                0, 0, 32'h555, 32'h55};
    vecs[6] = '{1, 1, 32'h660, 32'h66, 1, 0, 32'h661, 32'h67, 32'h6666_7777,
                TIE2, !TIE2, TIE2 ? 32'h661 : 32'h660, TIE2 ? 32'h67 : 32'h66};

    // reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wd", bus_wd, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_rd", m0_rd | m1_rd, 0);
    chk("rst_gnt", gnt_id, 0);

    // release at a falling edge; first vector is granted on the next rising edge
    @(negedge CLK);
    RST = 1'b1;

    foreach (vecs[i]) begin
      m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we;
      m0_addr = vecs[i].m0_addr; m0_wd = vecs[i].m0_wd;
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we;
      m1_addr = vecs[i].m1_addr; m1_wd = vecs[i].m1_wd;
      bus_rd = vecs[i].rd_in;
      cyc();  // ACCESS
      chk($sformatf("v%0d_acc_busy", i), busy, 1);
      chk($sformatf("v%0d_gnt", i), gnt_id, vecs[i].exp_gnt);
      chk($sformatf("v%0d_bus_we", i), bus_we, vecs[i].exp_we);
      chk($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_bus_wd", i), bus_wd, vecs[i].exp_wd);
      chk($sformatf("v%0d_acc_acks", i), {m0_ack, m1_ack}, 0);
      drop_reqs();
      cyc();  // RESP
      bus_rd = 32'hFFFF_FFFF;  // captured value must not follow the bridge now
      chk($sformatf("v%0d_m0_ack", i), m0_ack, !vecs[i].exp_gnt);
      chk($sformatf("v%0d_m1_ack", i), m1_ack, vecs[i].exp_gnt);
      chk($sformatf("v%0d_m0_rd", i), m0_rd, vecs[i].exp_gnt ? 32'h0 : vecs[i].rd_in);
      chk($sformatf("v%0d_m1_rd", i), m1_rd, vecs[i].exp_gnt ? vecs[i].rd_in : 32'h0);
      chk($sformatf("v%0d_resp_we", i), bus_we, 0);
      cyc();  // IDLE
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_idle_acks", i), {m0_ack, m1_ack}, 0);
      chk($sformatf("v%0d_idle_addr_hold", i), bus_addr, vecs[i].exp_addr);
    end

    // both requests held: back-to-back grants every 3 cycles
    RST = 1'b0; #1; RST = 1'b1;  // pointer back to master 1
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    bus_rd = 32'h0000_0B0B;
    for (int t = 0; t < 4; t++) begin
      logic exp_g;
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = t[0];
`endif
      cyc();
      chk($sformatf("b2b%0d_gnt", t), gnt_id, exp_g);
      chk($sformatf("b2b%0d_addr", t), bus_addr, exp_g ? 32'h20 : 32'h10);
      cyc();
      chk($sformatf("b2b%0d_acks", t), {m0_ack, m1_ack}, exp_g ? 2'b01 : 2'b10);
      cyc();
      chk($sformatf("b2b%0d_idle", t), busy, 0);
    end
    drop_reqs();
    cyc();

    // reset during ACCESS aborts the transaction and restores the pointer
    m0_req = 1; m0_we = 1; m0_addr = 32'h7F34; m0_wd = 32'hFF;
    cyc();
    chk("abort_we_before", bus_we, 1);
    #1 RST = 1'b0;
    #1;
    chk("abort_we_dropped", bus_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr_cleared", bus_addr, 0);
    drop_reqs();
    @(negedge CLK);
    RST = 1'b1;
    begin
      int seen_ack = 0;
      for (int t = 0; t < 4; t++) begin
        cyc();
        if (m0_ack || m1_ack || busy) seen_ack++;
      end
      chk("abort_no_ack", seen_ack, 0);
    end
    m0_req = 1; m0_we = 0; m0_addr = 32'hA0;
    m1_req = 1; m1_we = 0; m1_addr = 32'hB0;
    cyc();
    chk("abort_tie_gnt", gnt_id, 0);
    drop_reqs();
    cyc();
    cyc();

    // master inputs changing mid-transaction are ignored
    m0_req = 1; m0_we = 0; m0_addr = 32'h300; bus_rd = 32'h3030_3030;
    cyc();
    m0_addr = 32'h999; m0_we = 1; m0_wd = 32'h77;
    #1;
    chk("hold_addr", bus_addr, 32'h300);
    chk("hold_we", bus_we, 0);
    m0_req = 0;
    cyc();
    chk("hold_ack", m0_ack, 1);
    chk("hold_rd", m0_rd, 32'h3030_3030);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
